// File: rtl/cpu_types_pkg.sv
// Shared types for the memory arbiter: RAM handshake states, word type and
// the grant FSM state encoding.
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      FREE   = 2'd0,
      BUSY   = 2'd1,
      ACCESS = 2'd2,
      ERROR  = 2'd3
   } ramstate_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      IGNT = 2'd1,
      DGNT = 2'd2,
      DONE = 2'd3
   } arb_state_t;

   function automatic logic is_grant(input arb_state_t s);
      return (s == IGNT) || (s == DGNT);
   endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of requester, datapath-return and RAM-side signals around the arbiter.
// master = requesters plus RAM model, slave = the arbiter itself.
interface mem_arbiter_if;
   import cpu_types_pkg::*;

   logic      iREN;
   word_t     iaddr;
   logic      dREN;
   logic      dWEN;
   word_t     daddr;
   word_t     dstore;
   ramstate_t ram_state;
   word_t     ram_load;
   logic      ram_ren;
   logic      ram_wen;
   word_t     ram_addr;
   word_t     ram_store;
   logic      ihit;
   word_t     iload;
   logic      dhit;
   word_t     dload;
   logic      err;

   modport master (
      output iREN, iaddr, dREN, dWEN, daddr, dstore, ram_state, ram_load,
      input  ram_ren, ram_wen, ram_addr, ram_store, ihit, iload, dhit, dload, err
   );

   modport slave (
      input  iREN, iaddr, dREN, dWEN, daddr, dstore, ram_state, ram_load,
      output ram_ren, ram_wen, ram_addr, ram_store, ihit, iload, dhit, dload, err
   );

endinterface

// File: rtl/mem_port_mux.sv
// RAM-side select: picks address, write data and enables from the grant state.
// Everything is zero outside the two grant states.
module mem_port_mux
   import cpu_types_pkg::*;
(
   input  arb_state_t state,
   input  logic       dWEN,
   input  word_t      iaddr,
   input  word_t      daddr,
   input  word_t      dstore,
   output logic       ram_ren,
   output logic       ram_wen,
   output word_t      ram_addr,
   output word_t      ram_store
);

   always_comb begin
      ram_ren   = 1'b0;
      ram_wen   = 1'b0;
      ram_addr  = '0;
      ram_store = '0;
      case (state)
         IGNT: begin
            ram_ren  = 1'b1;
            ram_addr = iaddr;
         end
         DGNT: begin
            ram_addr = daddr;
            // a simultaneous read+write request is treated as a write
            if (dWEN) begin
               ram_wen   = 1'b1;
               ram_store = dstore;
            end else begin
               ram_ren = 1'b1;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between instruction fetch and data access, with
// round-robin on contention, one-cycle hit pulses and a grant watchdog.
module mem_arbiter
   import cpu_types_pkg::*;
#(
   parameter int TIMEOUT = 16
) (
   input logic         CLK,
   input logic         RST,
   mem_arbiter_if.slave bus
);

   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

   arb_state_t    state_reg;
   logic          last_d_reg;
   logic [TW-1:0] timer_reg;

   logic i_req;
   logic d_req;
   logic req_held;
   logic access;
   logic abort;

   assign i_req    = bus.iREN;
   assign d_req    = bus.dREN | bus.dWEN;
   assign req_held = (state_reg == IGNT) ? i_req : d_req;

   // a withdrawn request outranks ACCESS/ERROR: no pulse of any kind
   assign access = is_grant(state_reg) && req_held && (bus.ram_state == ACCESS);
   assign abort  = is_grant(state_reg) && req_held && !access &&
                   ((bus.ram_state == ERROR) || (timer_reg == TMAX));

   assign bus.ihit  = !RST && access && (state_reg == IGNT);
   assign bus.dhit  = !RST && access && (state_reg == DGNT);
   assign bus.err   = !RST && abort;
   assign bus.iload = bus.ihit ? bus.ram_load : '0;
   assign bus.dload = (bus.dhit && !bus.dWEN) ? bus.ram_load : '0;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_reg  <= IDLE;
         last_d_reg <= 1'b0;
         timer_reg  <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               timer_reg <= '0;
               if (d_req && (!i_req || !last_d_reg)) begin
                  state_reg <= DGNT;
               end else if (i_req) begin
                  state_reg <= IGNT;
               end
            end
            IGNT, DGNT: begin
               if (timer_reg != TMAX) begin
                  timer_reg <= timer_reg + TW'(1);
               end
               if (!req_held) begin
                  state_reg <= IDLE;
               end else if (access || abort) begin
                  state_reg  <= DONE;
                  last_d_reg <= (state_reg == DGNT);
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   mem_port_mux u_mux (
      .state     (state_reg),
      .dWEN      (bus.dWEN),
      .iaddr     (bus.iaddr),
      .daddr     (bus.daddr),
      .dstore    (bus.dstore),
      .ram_ren   (bus.ram_ren),
      .ram_wen   (bus.ram_wen),
      .ram_addr  (bus.ram_addr),
      .ram_store (bus.ram_store)
   );

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: expected hit/err responses go into a
// scoreboard queue, a negedge monitor pops them when the DUT pulses.
module tb_mem_arbiter;
   import cpu_types_pkg::*;

   typedef struct {
      logic [2:0]  kind;   // {ihit, dhit, err}
      logic [31:0] load;
      logic [31:0] addr;
      logic        wen;
   } exp_t;

   localparam logic [2:0] K_I = 3'b100;
   localparam logic [2:0] K_D = 3'b010;
   localparam logic [2:0] K_E = 3'b001;

   logic clk;
   logic rst;
   int   checks;
   int   errors;
   exp_t sb[$];
   exp_t e;

   mem_arbiter_if bus();

   mem_arbiter #(.TIMEOUT(16)) dut (
      .CLK (clk),
      .RST (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [2:0] kind, input logic [31:0] load,
                       input logic [31:0] addr, input logic wen);
      exp_t x;
      x.kind = kind;
      x.load = load;
      x.addr = addr;
      x.wen  = wen;
      sb.push_back(x);
   endtask

   always @(negedge clk) begin
      if (bus.ihit || bus.dhit || bus.err) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pulse: got ihit=%b dhit=%b err=%b expected none",
                     bus.ihit, bus.dhit, bus.err);
         end else begin
            e = sb.pop_front();
            chk("sb_kind", {29'd0, bus.ihit, bus.dhit, bus.err}, {29'd0, e.kind});
            chk("sb_load", bus.iload | bus.dload, e.load);
            chk("sb_addr", bus.ram_addr, e.addr);
            chk("sb_wen", {31'd0, bus.ram_wen}, {31'd0, e.wen});
            $display("txn t=%0t ihit=%b dhit=%b err=%b addr=%h load=%h",
                     $time, bus.ihit, bus.dhit, bus.err, bus.ram_addr, bus.iload | bus.dload);
         end
      end
   end

   initial begin
      checks        = 0;
      errors        = 0;
      rst           = 1'b1;
      bus.iREN      = 1'b0;
      bus.iaddr     = '0;
      bus.dREN      = 1'b0;
      bus.dWEN      = 1'b0;
      bus.daddr     = '0;
      bus.dstore    = '0;
      bus.ram_state = FREE;
      bus.ram_load  = '0;

      // reset
      repeat (2) tick();
      @(negedge clk);
      chk("rst_ren", {31'd0, bus.ram_ren}, 32'd0);
      chk("rst_wen", {31'd0, bus.ram_wen}, 32'd0);
      chk("rst_addr", bus.ram_addr, 32'd0);
      chk("rst_store", bus.ram_store, 32'd0);
      chk("rst_pulses", {29'd0, bus.ihit, bus.dhit, bus.err}, 32'd0);
      chk("rst_loads", bus.iload | bus.dload, 32'd0);
      tick();
      rst = 1'b0;

      // zero-wait instruction fetch
      bus.iREN      = 1'b1;
      bus.iaddr     = 32'h40;
      bus.ram_state = ACCESS;
      bus.ram_load  = 32'h8C220004;
      push(K_I, 32'h8C220004, 32'h40, 1'b0);
      tick();
      @(negedge clk);
      chk("fetch_ihit", {31'd0, bus.ihit}, 32'd1);
      chk("fetch_iload", bus.iload, 32'h8C220004);
      tick();
      bus.iREN      = 1'b0;
      bus.ram_state = FREE;
      @(negedge clk);
      chk("done_ren", {31'd0, bus.ram_ren}, 32'd0);
      chk("done_addr", bus.ram_addr, 32'd0);
      tick();

      // contention: data wins first, write with two BUSY cycles
      bus.iREN      = 1'b1;
      bus.iaddr     = 32'h44;
      bus.dWEN      = 1'b1;
      bus.daddr     = 32'h100;
      bus.dstore    = 32'hDEAD;
      bus.ram_state = BUSY;
      push(K_D, 32'h0, 32'h100, 1'b1);
      push(K_I, 32'h12345678, 32'h44, 1'b0);
      tick();
      @(negedge clk);
      chk("cont_wen", {31'd0, bus.ram_wen}, 32'd1);
      chk("cont_ren", {31'd0, bus.ram_ren}, 32'd0);
      chk("cont_addr", bus.ram_addr, 32'h100);
      chk("cont_store", bus.ram_store, 32'hDEAD);
      tick();
      @(negedge clk);
      chk("cont_busy_dhit", {31'd0, bus.dhit}, 32'd0);
      tick();
      bus.ram_state = ACCESS;
      tick();
      bus.dWEN      = 1'b0;
      bus.ram_state = FREE;
      tick();
      tick();
      bus.ram_state = ACCESS;
      bus.ram_load  = 32'h12345678;
      @(negedge clk);
      chk("cont_igrant_ren", {31'd0, bus.ram_ren}, 32'd1);
      tick();
      bus.iREN      = 1'b0;
      bus.ram_state = FREE;
      tick();

      // round robin with both requests held: D, I, D, I
      bus.iREN      = 1'b1;
      bus.dREN      = 1'b1;
      bus.iaddr     = 32'h80;
      bus.daddr     = 32'h200;
      bus.ram_state = ACCESS;
      bus.ram_load  = 32'hA5A50000;
      for (int k = 0; k < 2; k++) begin
         push(K_D, 32'hA5A50000, 32'h200, 1'b0);
         push(K_I, 32'hA5A50000, 32'h80, 1'b0);
      end
      repeat (11) tick();
      bus.iREN      = 1'b0;
      bus.dREN      = 1'b0;
      bus.ram_state = FREE;
      tick();

      // timeout on a stuck data read, instruction pending behind it
      bus.dREN      = 1'b1;
      bus.daddr     = 32'h300;
      bus.iREN      = 1'b1;
      bus.iaddr     = 32'h84;
      bus.ram_state = BUSY;
      push(K_E, 32'h0, 32'h300, 1'b0);
      tick();
      repeat (14) tick();
      @(negedge clk);
      chk("timeout_early_err", {31'd0, bus.err}, 32'd0);
      tick();
      @(negedge clk);
      chk("timeout_err", {31'd0, bus.err}, 32'd1);
      chk("timeout_dhit", {31'd0, bus.dhit}, 32'd0);
      tick();
      tick();
      tick();
      @(negedge clk);
      chk("post_timeout_ren", {31'd0, bus.ram_ren}, 32'd1);
      chk("post_timeout_addr", bus.ram_addr, 32'h84);

      // withdraw the fetch mid-grant
      tick();
      bus.iREN = 1'b0;
      bus.dREN = 1'b0;
      @(negedge clk);
      chk("withdraw_ihit", {31'd0, bus.ihit}, 32'd0);
      tick();
      @(negedge clk);
      chk("withdraw_ren", {31'd0, bus.ram_ren}, 32'd0);
      chk("withdraw_addr", bus.ram_addr, 32'd0);

      // reset during a data write grant
      bus.dWEN      = 1'b1;
      bus.daddr     = 32'h400;
      bus.dstore    = 32'hBEEF;
      bus.ram_state = BUSY;
      tick();
      @(negedge clk);
      chk("rstg_wen", {31'd0, bus.ram_wen}, 32'd1);
      tick();
      rst           = 1'b1;
      bus.ram_state = ACCESS;
      @(negedge clk);
      chk("rstg_dhit", {31'd0, bus.dhit}, 32'd0);
      tick();
      @(negedge clk);
      chk("rstg_wen_drop", {31'd0, bus.ram_wen}, 32'd0);
      chk("rstg_addr", bus.ram_addr, 32'd0);
      tick();
      rst           = 1'b0;
      bus.dWEN      = 1'b0;
      bus.ram_state = FREE;
      repeat (2) tick();

      chk("sb_drain", sb.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
